// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    // Core side: issues operations and consumes results.
    modport master (
        output flush, in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, result, zero
    );

    // Unit side.
    modport slave (
        input  flush, in_valid, op, A, B, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with divide fast path.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic               neg_q;      // quotient/product sign flip
    logic               rem_neg_q;  // remainder follows dividend sign
    logic [WIDTH-1:0]   b_mag_q;
    logic [PROD_W-1:0]  acc_q;      // {partial product | remainder, multiplier | quotient}
    logic [WIDTH-1:0]   result_q;
    logic               out_valid_q;
    logic               in_ready_q;

    // Accept-time decode: signedness, magnitudes and fast-path result.
    logic               a_signed_d;
    logic               b_signed_d;
    logic               a_neg_d;
    logic               b_neg_d;
    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               b_zero_d;
    logic               ovf_d;
    logic               fast_d;
    logic [WIDTH-1:0]   fast_res_d;

    // Decode request operands while idle.
    always_comb begin
        a_signed_d = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
        b_signed_d = a_signed_d && (bus.op != OP_MULHSU);
        a_neg_d    = a_signed_d && bus.A[WIDTH-1];
        b_neg_d    = b_signed_d && bus.B[WIDTH-1];
        a_mag_d    = a_neg_d ? (~bus.A + WIDTH'(1)) : bus.A;
        b_mag_d    = b_neg_d ? (~bus.B + WIDTH'(1)) : bus.B;
        b_zero_d   = (bus.B == '0);
        ovf_d      = !bus.op[0] && (bus.A == MIN_NEG) && (bus.B == ALL_ONE);
        fast_d     = bus.op[2] && (b_zero_d || ovf_d);
        fast_res_d = '0;
        if (b_zero_d) begin
            fast_res_d = bus.op[1] ? bus.A : ALL_ONE;
        end else begin
            fast_res_d = bus.op[1] ? '0 : bus.A;
        end
    end

    // One iteration step plus sign correction of the would-be final value.
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shift_rem;
    logic [WIDTH:0]     sub_diff;
    logic [PROD_W-1:0]  acc_d;
    logic [PROD_W-1:0]  prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   calc_res_d;

    // Shift-add for multiply, restoring subtract for divide.
    always_comb begin
        acc_hi    = acc_q[PROD_W-1:WIDTH];
        acc_lo    = acc_q[WIDTH-1:0];
        add_sum   = '0;
        shift_rem = '0;
        sub_diff  = '0;
        acc_d     = acc_q;
        if (!op_q[2]) begin
            add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag_q} : '0);
            acc_d   = {add_sum, acc_lo[WIDTH-1:1]};
        end else begin
            shift_rem = {acc_hi, acc_lo[WIDTH-1]};
            sub_diff  = shift_rem - {1'b0, b_mag_q};
            if (!sub_diff[WIDTH]) begin
                acc_d = {sub_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {shift_rem[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign-correct and select the architectural result.
    always_comb begin
        prod_fix = neg_q ? (~acc_d + PROD_W'(1)) : acc_d;
        quo_fix  = neg_q ? (~acc_d[WIDTH-1:0] + WIDTH'(1)) : acc_d[WIDTH-1:0];
        rem_fix  = rem_neg_q ? (~acc_d[PROD_W-1:WIDTH] + WIDTH'(1)) : acc_d[PROD_W-1:WIDTH];
        calc_res_d = '0;
        case (op_q)
            OP_MUL:                        calc_res_d = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  calc_res_d = prod_fix[PROD_W-1:WIDTH];
            OP_DIV, OP_DIVU:               calc_res_d = quo_fix;
            OP_REM, OP_REMU:               calc_res_d = rem_fix;
            default:                       calc_res_d = '0;
        endcase
    end

    // Control FSM and datapath registers; reset, then flush, take priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            b_mag_q     <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (bus.flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.op;
                        neg_q      <= a_neg_d ^ b_neg_d;
                        rem_neg_q  <= a_neg_d;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (fast_d) begin
                            result_q    <= fast_res_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            b_mag_q <= b_mag_d;
                            acc_q   <= {{WIDTH{1'b0}}, a_mag_d};
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_q       <= '0;
                        result_q    <= calc_res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);

endmodule
